// File: rtl/cursor_uart_rx.sv
// rtl/cursor_uart_rx.sv - 8N1 UART receiver with 0xAA cursor packet parser
module cursor_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        pkt_valid,
    output logic [1:0]  buttons,
    output logic [7:0]  dx,
    output logic [7:0]  dy,
    output logic        chk_err,
    output logic        frame_err,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_END = TW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} byte_state_t;
    typedef enum logic [2:0] {P_HUNT, P_BTN, P_DX, P_DY, P_CHK} pkt_state_t;

    logic [1:0]    sync;
    logic          rx_s;
    logic          rx_prev;
    logic          fall;
    byte_state_t   b_state, b_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_tick;
    logic          byte_done;
    logic          frame_evt;

    pkt_state_t    p_state, p_next;
    logic [7:0]    sh_btn, sh_dx, sh_dy;
    logic [TW-1:0] to_cnt;
    logic          chk_ok;
    logic          good_evt;
    logic          chk_evt;
    logic          timeout_evt;
    logic [1:0]    err_inc;
    logic [16:0]   err_sum;

    // Flops reset high so the line reads idle and no false start edge appears at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rx};
            rx_prev <= sync[1];
        end
    end

    assign rx_s = sync[1];
    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_state <= B_IDLE;
        else        b_state <= b_next;
    end

    always_comb begin
        b_next = b_state;
        case (b_state)
            B_IDLE:  if (fall) b_next = B_START;
            B_START: if (cnt == HALF_END) b_next = rx_s ? B_IDLE : B_DATA;
            B_DATA:  if (cnt == BIT_END && bit_idx == 3'd7) b_next = B_STOP;
            B_STOP:  if (cnt == BIT_END) b_next = rx_s ? B_IDLE : B_BREAK;
            B_BREAK: if (rx_s) b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
    end

    always_comb begin
        bit_tick  = ((b_state == B_START) && (cnt == HALF_END)) ||
                    (((b_state == B_DATA) || (b_state == B_STOP)) && (cnt == BIT_END));
        byte_done = (b_state == B_STOP) && (cnt == BIT_END) && rx_s;
        frame_evt = (b_state == B_STOP) && (cnt == BIT_END) && !rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (b_state == B_IDLE || b_state == B_BREAK || bit_tick) cnt <= '0;
            else                                                      cnt <= cnt + 1'b1;
            if (b_state == B_START) bit_idx <= '0;
            else if (b_state == B_DATA && bit_tick) begin
                bit_idx <= bit_idx + 1'b1;
                shift   <= {rx_s, shift[7:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_state <= P_HUNT;
        else        p_state <= p_next;
    end

    // Frame errors and timeouts abort any partial packet; resync only from HUNT.
    always_comb begin
        p_next = p_state;
        if (frame_evt || timeout_evt) p_next = P_HUNT;
        else if (byte_done) begin
            case (p_state)
                P_HUNT:  p_next = (shift == 8'hAA) ? P_BTN : P_HUNT;
                P_BTN:   p_next = P_DX;
                P_DX:    p_next = P_DY;
                P_DY:    p_next = P_CHK;
                P_CHK:   p_next = P_HUNT;
                default: p_next = P_HUNT;
            endcase
        end
    end

    always_comb begin
        chk_ok      = (shift == (sh_btn ^ sh_dx ^ sh_dy)) && (sh_btn[7:2] == 6'd0);
        good_evt    = byte_done && (p_state == P_CHK) && chk_ok;
        chk_evt     = byte_done && (p_state == P_CHK) && !chk_ok;
        timeout_evt = (p_state != P_HUNT) && !byte_done && (to_cnt == TO_END);
        err_inc     = 2'({1'b0, chk_evt}) + 2'({1'b0, frame_evt}) + 2'({1'b0, timeout_evt});
        err_sum     = {1'b0, err_count} + 17'(err_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            sh_btn <= '0;
            sh_dx  <= '0;
            sh_dy  <= '0;
        end else begin
            if (p_state == P_HUNT || byte_done) to_cnt <= '0;
            else                                to_cnt <= to_cnt + 1'b1;
            if (byte_done) begin
                if (p_state == P_BTN) sh_btn <= shift;
                if (p_state == P_DX)  sh_dx  <= shift;
                if (p_state == P_DY)  sh_dy  <= shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid <= 1'b0;
            chk_err   <= 1'b0;
            frame_err <= 1'b0;
            buttons   <= '0;
            dx        <= '0;
            dy        <= '0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            pkt_valid <= good_evt;
            chk_err   <= chk_evt;
            frame_err <= frame_evt;
            if (good_evt) begin
                buttons <= sh_btn[1:0];
                dx      <= sh_dx;
                dy      <= sh_dy;
                if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 1'b1;
            end
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule

// File: doc/cursor_uart_rx.md
Name: cursor_uart_rx

Overview:
- Receive-side counterpart of the cursor UART transmitter.
- Deserialises an 8N1 UART stream and re-frames the robust 0xAA cursor packet.
- Presents validated button/dx/dy fields with a one-cycle strobe.
- Used by the host-side bridge FPGA and as the self-checking loopback monitor in system benches.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 8.
- TIMEOUT_BITS, 20, max idle bit-times between bytes of one packet before the parser aborts.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  UART serial input, idle high, asynchronous to clk
- pkt_valid  output  1  one-cycle strobe: fields below updated with a good packet
- buttons  output  2  {right, left} latched from the last good packet
- dx  output  8  signed X delta from the last good packet
- dy  output  8  signed Y delta from the last good packet
- chk_err  output  1  one-cycle strobe: packet dropped (checksum or reserved-bit failure)
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- pkt_count  output  16  good packets received, saturates at 0xFFFF
- err_count  output  16  chk_err + frame_err + timeout events, saturates at 0xFFFF

Behaviour:
- Reset: all outputs 0; both FSMs idle; synchroniser flops set to 1.
- Packet format: 5 bytes, LSB-first 8N1.
  - B0 = 0xAA
  - B1 = {6'b0, right, left}
  - B2 = dx
  - B3 = dy
  - B4 = B1 ^ B2 ^ B3
- rx path: 2-FF synchroniser. All sampling uses the synchronised signal.
- Byte FSM:
  - IDLE: waits for a falling edge.
  - START: samples at CLKS_PER_BIT/2. If high, treat as a glitch and return to IDLE with no error.
  - DATA: samples 8 bits, each CLKS_PER_BIT after the previous sample (bit-centre).
  - STOP: samples once.
    - High: emit byte_done for 1 cycle.
    - Low: pulse frame_err, discard the byte, then wait for rx high before returning to IDLE (break-safe).
- Parser FSM (advances on byte_done):
  - HUNT: 0xAA goes to BTN; any other byte stays in HUNT silently.
  - BTN → DX → DY → CHK, capturing each byte into shadow registers.
  - CHK: good if B4 matches and B1[7:2]==0.
    - Good: copy shadows to outputs, pulse pkt_valid, increment pkt_count.
    - Otherwise: pulse chk_err and leave outputs unchanged.
    - Both cases return to HUNT.
- Payload bytes equal to 0xAA are accepted positionally; resync happens only from HUNT.
- Latency: pkt_valid and output update occur 1 clk after the byte_done of B4. Outputs hold until the next good packet.
- Frame error while the parser is outside HUNT: byte discarded, parser returns to HUNT, partial packet dropped, no chk_err.
- Timeout:
  - While the parser is outside HUNT, a cycle counter resets on each byte_done.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT forces HUNT and increments err_count; no strobe.
- err_count increments once per event. If two events coincide in one cycle, it increments by the event count, saturating.
- chk_err, frame_err and pkt_valid are never high in the same cycle as reset release.
- Reset asserted mid-byte or mid-packet: immediate return to reset state. The first packet after release must start with a fresh idle-to-start edge.

Test Plan:
- CLKS_PER_BIT=16. Send AA 01 05 FB FF → pkt_valid once, buttons=2'b01, dx=+5, dy=-5, pkt_count=1, err_count=0.
- Send AA 02 10 20 00 (bad checksum; correct is 0x32) → chk_err once, no pkt_valid, outputs keep previous values, err_count=1.
- Send 55 13 AA 00 AA 00 AA (leading junk, AA payloads) → single pkt_valid with buttons=0, dx=-86 (0xAA), dy=0.
- Send AA 03 then hold rx high for 21 bit-times, then a good packet AA 03 01 01 03 → timeout increments err_count by 1; the following packet gives pkt_valid with buttons=2'b11, dx=1, dy=1.
- Send byte B2 with its stop bit driven low → frame_err pulse, packet dropped, parser in HUNT; the next good packet is accepted.
- Assert rst_n low during DATA of B3, release, then send a good packet → all outputs 0 during reset, exactly one pkt_valid afterwards, pkt_count=1.
